// File: rtl/register_file_2w2r_pkg.sv
// Shared types and defaults for the dual-write, dual-read register file.
package register_file_2w2r_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_DEPTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/register_file_2w2r_clear_fsm.sv
// Sequential clear controller: sweeps one register per cycle and reports busy.
module regfile_clear_fsm
    import register_file_2w2r_pkg::*;
#(
    parameter  int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req_i,
    output logic          busy_o,
    output logic [AW-1:0] clr_addr_o
);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // busy is registered from the next state so it tracks state_q exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == CLEAR);
        end
    end

    assign busy_o     = busy_q;
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/register_file_2w2r.sv
// Register file with two write ports, two combinational read ports,
// optional hardwired-zero register 0, write-to-read bypass and a sequential clear.
module register_file_2w2r
    import register_file_2w2r_pkg::*;
#(
    parameter  int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter  int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter  bit          ZERO_REG = 1'b1,
    parameter  bit          BYPASS   = 1'b1,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en0,
    input  logic [AW-1:0]    wr_addr0,
    input  logic [WIDTH-1:0] wr_data0,
    input  logic             wr_en1,
    input  logic [AW-1:0]    wr_addr1,
    input  logic [WIDTH-1:0] wr_data1,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    input  logic             clr_req,
    output logic             busy
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [AW-1:0]    clr_addr;
    logic             we0, we1;
    logic [AW-1:0]    rd_addr [2];
    logic [WIDTH-1:0] rd_val  [2];

    regfile_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req_i  (clr_req),
        .busy_o     (busy),
        .clr_addr_o (clr_addr)
    );

    assign we0 = wr_en0 && !busy && !(ZERO_REG && (wr_addr0 == '0));
    assign we1 = wr_en1 && !busy && !(ZERO_REG && (wr_addr1 == '0));

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (busy) begin
            regs_q[clr_addr] <= '0;
        end else begin
            if (we0) regs_q[wr_addr0] <= wr_data0;
            if (we1) regs_q[wr_addr1] <= wr_data1;
        end
    end

    assign rd_addr[0] = rd_addr1;
    assign rd_addr[1] = rd_addr2;

    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            rd_val[p] = regs_q[rd_addr[p]];
            if (BYPASS && !busy) begin
                if (wr_en0 && (wr_addr0 == rd_addr[p])) rd_val[p] = wr_data0;
                if (wr_en1 && (wr_addr1 == rd_addr[p])) rd_val[p] = wr_data1;
            end
            if (ZERO_REG && (rd_addr[p] == '0)) rd_val[p] = '0;
        end
    end

    assign rd_data1 = rd_val[0];
    assign rd_data2 = rd_val[1];

endmodule
